// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen -- fetch program-counter generator with branch checkpoints.
//
// Each cycle the PC advances by one fetch group. The exceptions are replay,
// which advances by one instruction, stall, which holds, and a taken branch
// from decode (redirect), which jumps to the branch target. Every accepted
// redirect pushes its fall-through address into a small checkpoint FIFO.
// When the oldest branch resolves, a correct prediction pops the head. A
// mispredict restores the PC from the head and discards all checkpoints.
//
// Ports:
//   clk                 in   1         clock, rising edge
//   reset_n             in   1         asynchronous active-low reset
//   stall               in   1         hold PC (recovery and pops still honoured)
//   replay              in   1         advance by one instruction only
//   redirect_valid      in   1         taken branch presented by decode
//   redirect_slot       in   1         branch slot in fetch group (0 first, 1 second)
//   redirect_offset     in   32        signed branch offset, in instructions
//   resolve_valid       in   1         oldest checkpointed branch resolved
//   resolve_mispredict  in   1         qualifies resolve_valid: recover
//   redirect_ready      out  1         redirect accepted this cycle (combinational)
//   pc_out              out  PC_W      current fetch PC
//   ckpt_count          out  CNT_W     number of valid checkpoints
//   ckpt_full           out  1         ckpt_count == CKPT_DEPTH
//   ckpt_underflow      out  1         sticky: resolve seen with no checkpoint

module fetch_pc_gen #(
    parameter int              PC_W        = 8,
    parameter int              INSTR_BYTES = 4,
    parameter int              FETCH_W     = 2,
    parameter int              CKPT_DEPTH  = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          stall,
    input  logic                          replay,
    input  logic                          redirect_valid,
    input  logic                          redirect_slot,
    input  logic [31:0]                   redirect_offset,
    input  logic                          resolve_valid,
    input  logic                          resolve_mispredict,
    output logic                          redirect_ready,
    output logic [PC_W-1:0]               pc_out,
    output logic [$clog2(CKPT_DEPTH):0]   ckpt_count,
    output logic                          ckpt_full,
    output logic                          ckpt_underflow
);

    localparam int PTR_W = $clog2(CKPT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PC_W-1:0] SEQ_STEP    = PC_W'(FETCH_W * INSTR_BYTES);
    localparam logic [PC_W-1:0] INSTR_STEP  = PC_W'(INSTR_BYTES);
    localparam logic [PC_W-1:0] INSTR_STEP2 = PC_W'(2 * INSTR_BYTES);
    localparam logic [31:0]     INSTR_B32   = 32'(INSTR_BYTES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PC_W-1:0]  r_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_underflow;
    logic [PC_W-1:0]  r_ckpt [CKPT_DEPTH];

    // ------------------------------------------------------------------
    // Decode of this cycle's events
    // ------------------------------------------------------------------
    logic            w_full;
    logic            w_empty;
    logic            w_mispredict;
    logic            w_recover;
    logic            w_pop;
    logic            w_push;
    logic            w_underflow_evt;
    logic [PC_W-1:0] w_redirect_target;
    logic [PC_W-1:0] w_fall_through;
    logic [PC_W-1:0] w_pc_next;

    assign w_full       = (r_count == CNT_W'(CKPT_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_mispredict = resolve_valid & resolve_mispredict;

    // A resolve with nothing checkpointed is ignored apart from the error
    // flag, so recovery and pops are gated by occupancy.
    assign w_recover       = w_mispredict & ~w_empty;
    assign w_pop           = resolve_valid & ~resolve_mispredict & ~w_empty;
    assign w_underflow_evt = resolve_valid & w_empty;

    assign redirect_ready = redirect_valid & ~w_full & ~stall & ~replay & ~w_mispredict;
    assign w_push         = redirect_ready;

    // The offset is computed modulo 2^32 and then cut to PC width. Two's
    // complement makes this correct for negative offsets without sign handling.
    assign w_redirect_target = r_pc + PC_W'((redirect_offset + 32'(redirect_slot)) * INSTR_B32);
    assign w_fall_through    = r_pc + (redirect_slot ? INSTR_STEP2 : INSTR_STEP);

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_pc_next = r_pc;
        if (w_recover) begin
            w_pc_next = r_ckpt[r_head];
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (replay) begin
            w_pc_next = r_pc + INSTR_STEP;
        end else if (redirect_valid) begin
            // A refused redirect holds the PC so decode can re-present it.
            if (redirect_ready) begin
                w_pc_next = w_redirect_target;
            end
        end else begin
            w_pc_next = r_pc + SEQ_STEP;
        end
    end

    // ------------------------------------------------------------------
    // PC, pointers, count, error flag
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc        <= RESET_PC;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_underflow_evt) begin
                r_underflow <= 1'b1;
            end
            if (w_recover) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // NOTE: the checkpoint storage has no reset. An entry is read only after
    // it has been written, and the pointers and count, which are reset,
    // decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ckpt[r_tail] <= w_fall_through;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registers or functions of registers only
    // ------------------------------------------------------------------
    assign pc_out         = r_pc;
    assign ckpt_count     = r_count;
    assign ckpt_full      = w_full;
    assign ckpt_underflow = r_underflow;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen -- directed self-checking bench for fetch_pc_gen with the
// default parameters (PC_W=8, INSTR_BYTES=4, FETCH_W=2, CKPT_DEPTH=4).
// The bench drives inputs 1 time unit after a rising edge and checks
// outputs just before the next edge. All expected values are computed by
// hand.

module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        replay;
    logic        redirect_valid;
    logic        redirect_slot;
    logic [31:0] redirect_offset;
    logic        resolve_valid;
    logic        resolve_mispredict;
    logic        redirect_ready;
    logic [7:0]  pc_out;
    logic [2:0]  ckpt_count;
    logic        ckpt_full;
    logic        ckpt_underflow;

    int checks = 0;
    int errors = 0;

    fetch_pc_gen dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .stall              (stall),
        .replay             (replay),
        .redirect_valid     (redirect_valid),
        .redirect_slot      (redirect_slot),
        .redirect_offset    (redirect_offset),
        .resolve_valid      (resolve_valid),
        .resolve_mispredict (resolve_mispredict),
        .redirect_ready     (redirect_ready),
        .pc_out             (pc_out),
        .ckpt_count         (ckpt_count),
        .ckpt_full          (ckpt_full),
        .ckpt_underflow     (ckpt_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall              = 1'b0;
        replay             = 1'b0;
        redirect_valid     = 1'b0;
        redirect_slot      = 1'b0;
        redirect_offset    = 32'd0;
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic redirect(input logic slot, input logic [31:0] ofs);
        redirect_valid  = 1'b1;
        redirect_slot   = slot;
        redirect_offset = ofs;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #2;
        // Reset state, with a redirect presented to check that ready still
        // follows its combinational equation.
        check("reset_pc", pc_out, 32'h00);
        check("reset_count", ckpt_count, 32'd0);
        check("reset_full", ckpt_full, 32'd0);
        check("reset_underflow", ckpt_underflow, 32'd0);
        redirect(1'b0, 32'd3);
        #1;
        check("reset_ready_follows_eq", redirect_ready, 32'd1);
        step();
        check("reset_holds_pc", pc_out, 32'h00);
        idle_inputs();
        step();
        reset_n = 1'b1;
        check("release_pc", pc_out, 32'h00);

        // Sequential fetch.
        step(); check("seq_1", pc_out, 32'h08);
        step(); check("seq_2", pc_out, 32'h10);
        step(); check("seq_3", pc_out, 32'h18);

        // Redirect plus correct resolve.
        do_reset();
        step(); step();
        check("r23_start_pc", pc_out, 32'h10);
        redirect(1'b1, 32'd3);
        #1; check("r23_ready", redirect_ready, 32'd1);
        step();
        check("r23_target_pc", pc_out, 32'h20);
        check("r23_count_1", ckpt_count, 32'd1);
        idle_inputs();
        resolve_valid = 1'b1;
        step();
        check("r23_resolve_count", ckpt_count, 32'd0);
        check("r23_resolve_pc", pc_out, 32'h28);
        idle_inputs();

        // Mispredict recovery under stall; a redirect in the same cycle is dropped.
        do_reset();
        step(); step();
        redirect(1'b0, 32'd5);
        step();
        check("r24_target_pc", pc_out, 32'h24);
        check("r24_count_1", ckpt_count, 32'd1);
        resolve_valid = 1'b1; resolve_mispredict = 1'b1; stall = 1'b1;
        #1; check("r24_ready_dropped", redirect_ready, 32'd0);
        step();
        check("r24_recover_pc", pc_out, 32'h14);
        check("r24_recover_count", ckpt_count, 32'd0);
        idle_inputs();

        // Replay and stall.
        replay = 1'b1;
        step(); check("replay_pc", pc_out, 32'h18);
        replay = 1'b0; stall = 1'b1;
        step(); check("stall_pc", pc_out, 32'h18);
        stall = 1'b0;

        // Fill the FIFO: slot 0, offset 1 -> target = fall-through = pc+4.
        redirect(1'b0, 32'd1);
        step(); step(); step(); step();
        check("r25_fill_pc", pc_out, 32'h28);
        check("r25_fill_count", ckpt_count, 32'd4);
        check("r25_full", ckpt_full, 32'd1);
        #1; check("r25_fifth_not_ready", redirect_ready, 32'd0);
        step();
        check("r25_fifth_pc_held", pc_out, 32'h28);
        resolve_valid = 1'b1;
        #1; check("r25_ready_still_full", redirect_ready, 32'd0);
        step();
        check("r25_pop_pc_held", pc_out, 32'h28);
        check("r25_pop_count", ckpt_count, 32'd3);
        check("r25_not_full", ckpt_full, 32'd0);
        resolve_valid = 1'b0;
        #1; check("r25_represent_ready", redirect_ready, 32'd1);
        step();
        check("r25_accept_pc", pc_out, 32'h2C);
        check("r25_refill_count", ckpt_count, 32'd4);
        // FIFO now holds 0x20,0x24,0x28,0x2C.
        idle_inputs();
        resolve_valid = 1'b1;
        step();
        check("pop_alone_pc", pc_out, 32'h34);
        check("pop_alone_count", ckpt_count, 32'd3);
        // Pop and push together: target 0x34+3*4, fall-through 0x34+8.
        redirect(1'b1, 32'd2);
        step();
        check("popush_pc", pc_out, 32'h40);
        check("popush_count", ckpt_count, 32'd3);
        // FIFO holds 0x28,0x2C,0x3C with wrapped pointers; head must be 0x28.
        idle_inputs();
        resolve_valid = 1'b1; resolve_mispredict = 1'b1;
        step();
        check("order_recover_pc", pc_out, 32'h28);
        check("order_recover_count", ckpt_count, 32'd0);
        idle_inputs();

        // Wrap-around and negative offset.
        redirect(1'b0, 32'd52);               // 0x28 + 208 = 0xF8
        step(); check("wrap_setup_pc", pc_out, 32'hF8);
        idle_inputs();
        step(); check("wrap_seq_pc", pc_out, 32'h00);
        replay = 1'b1;
        step(); check("wrap_replay_pc", pc_out, 32'h04);
        replay = 1'b0;
        redirect(1'b0, 32'hFFFF_FFFE);        // offset -2
        step();
        check("neg_offset_pc", pc_out, 32'hFC);
        check("neg_offset_count", ckpt_count, 32'd2);
        idle_inputs();
        resolve_valid = 1'b1;
        step(); step();
        check("drain_pc", pc_out, 32'h0C);
        check("drain_count", ckpt_count, 32'd0);

        // Resolve on an empty FIFO, held by stall so the PC must not move.
        resolve_mispredict = 1'b1; stall = 1'b1;
        step();
        check("underflow_flag", ckpt_underflow, 32'd1);
        check("underflow_pc", pc_out, 32'h0C);
        check("underflow_count", ckpt_count, 32'd0);
        idle_inputs();
        redirect(1'b1, 32'd1);                // 0x0C + 2*4 = 0x14
        step();
        check("underflow_sticky", ckpt_underflow, 32'd1);
        check("post_underflow_pc", pc_out, 32'h14);
        check("post_underflow_count", ckpt_count, 32'd1);
        idle_inputs();

        // Asynchronous reset between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_pc", pc_out, 32'h00);
        check("async_count", ckpt_count, 32'd0);
        check("async_underflow", ckpt_underflow, 32'd0);
        check("async_full", ckpt_full, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("after_async_first_pc", pc_out, 32'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
